fibonacci_wb: RTL and testbench

// - Parametrised Wishbone-slave sequence generator: next generation of the team's fibonacci block.
// - Adds selectable Fibonacci/Lucas seeds, busy/done/overflow status, an interrupt, and a generic result width.
// - Sits in user_project_wrapper on the MGMT SoC Wishbone bus (wb_clk_i domain); irq drives user_irq[0].

---
 rtl/fibonacci_wb_pkg.sv | 33 +++
 rtl/fibonacci_wb_if.sv | 21 ++
 rtl/fibonacci_wb_fib_core.sv | 74 +++++++
 rtl/fibonacci_wb.sv | 106 ++++++++++
 tb/tb_fibonacci_wb.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fibonacci_wb_pkg.sv
// Shared definitions for the fibonacci_wb sequence generator: register map,
// bit positions, mode codes, FSM state type and a byte-lane merge helper.
package fibonacci_wb_pkg;

   localparam logic [1:0] RegCtrl   = 2'd0;
   localparam logic [1:0] RegN      = 2'd1;
   localparam logic [1:0] RegResult = 2'd2;
   localparam logic [1:0] RegStatus = 2'd3;

   localparam int unsigned CtrlStart = 0;
   localparam int unsigned CtrlMode  = 1;
   localparam int unsigned CtrlIrqEn = 2;

   localparam int unsigned StatBusy = 0;
   localparam int unsigned StatDone = 1;
   localparam int unsigned StatOvf  = 2;

   localparam logic ModeFib   = 1'b0;
   localparam logic ModeLucas = 1'b1;

   typedef enum logic {StIdle, StRun} state_e;

   function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/fibonacci_wb_if.sv
// Wishbone slave bus bundle for fibonacci_wb; signal suffixes are from the slave's view.
interface fibonacci_wb_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/fibonacci_wb_fib_core.sv
// Sequence engine: two-term recurrence with per-term overflow tracking.
// Loads seeds on i_start, steps N times, then pulses o_done_pulse for one cycle.
module fib_core
   import fibonacci_wb_pkg::*;
#(
   parameter int unsigned W  = 32,
   parameter int unsigned NW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_mode,
   input  logic [NW-1:0] i_n,
   output logic          o_busy,
   output logic          o_done_pulse,
   output logic [W-1:0]  o_result,
   output logic          o_ovf
);

   state_e        r_state, w_state_nxt;
   logic [W-1:0]  r_a, r_b;
   logic [NW-1:0] r_cnt;
   logic          r_oa, r_ob;
   logic [W:0]    w_sum;

   assign w_sum = {1'b0, r_a} + {1'b0, r_b};

   always_comb begin
      w_state_nxt  = r_state;
      o_done_pulse = 1'b0;
      unique case (r_state)
         StIdle: if (i_start) w_state_nxt = StRun;
         StRun: begin
            if (r_cnt == '0) begin
               o_done_pulse = 1'b1;
               w_state_nxt  = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_oa    <= 1'b0;
         r_ob    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == StIdle && i_start) begin
            r_a   <= (i_mode == ModeLucas) ? W'(2) : '0;
            r_b   <= W'(1);
            r_cnt <= i_n;
            r_oa  <= 1'b0;
            r_ob  <= 1'b0;
         end else if (r_state == StRun && r_cnt != '0) begin
            r_a   <= r_b;
            r_b   <= w_sum[W-1:0];
            r_cnt <= r_cnt - 1'b1;
            r_oa  <= r_ob;
            // A term is out of range once either addend was, or this add carries.
            r_ob  <= r_ob | r_oa | w_sum[W];
         end
      end
   end

   assign o_busy   = (r_state == StRun);
   assign o_result = r_a;
   assign o_ovf    = r_oa;

endmodule

// File: rtl/fibonacci_wb.sv
// Wishbone-slave Fibonacci/Lucas generator: bus decode, register file,
// status flags and level interrupt around the fib_core engine.
module fibonacci_wb
   import fibonacci_wb_pkg::*;
#(
   parameter int unsigned W         = 32,
   parameter int unsigned NW        = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   fibonacci_wb_if.slave  wbs,
   output logic           irq
);

   logic          r_ack;
   logic [31:0]   r_dat;
   logic          r_mode, r_irq_en, r_done, r_ovf;
   logic [NW-1:0] r_n;
   logic [W-1:0]  r_result;

   logic          w_hit, w_wr, w_start, w_busy, w_done_pulse, w_core_ovf;
   logic [1:0]    w_reg;
   logic [31:0]   w_rdata, w_old, w_wmerge;
   logic [W-1:0]  w_core_result;
   logic          w_unused;

   assign w_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack &
                  (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_wr  = w_hit & wbs.wbs_we_i;
   assign w_reg = wbs.wbs_adr_i[3:2];

   always_comb begin
      w_rdata = '0;
      unique case (w_reg)
         RegCtrl:   w_rdata = {29'b0, r_irq_en, r_mode, 1'b0};
         RegN:      w_rdata = 32'(r_n);
         RegResult: w_rdata = 32'(r_result);
         RegStatus: w_rdata = {29'b0, r_ovf, r_done, w_busy};
         default:   w_rdata = '0;
      endcase
   end

   // Unselected lanes keep the register's value; STATUS merges against zero so
   // an unselected lane never clears a flag.
   assign w_old    = (w_reg == RegCtrl || w_reg == RegN) ? w_rdata : '0;
   assign w_wmerge = sel_merge(w_old, wbs.wbs_dat_i, wbs.wbs_sel_i);
   assign w_start  = w_wr & (w_reg == RegCtrl) & w_wmerge[CtrlStart] & ~w_busy;

   fib_core #(
      .W  (W),
      .NW (NW)
   ) u_core (
      .i_clk        (wb_clk_i),
      .i_rst        (wb_rst_i),
      .i_start      (w_start),
      .i_mode       (w_wmerge[CtrlMode]),
      .i_n          (r_n),
      .o_busy       (w_busy),
      .o_done_pulse (w_done_pulse),
      .o_result     (w_core_result),
      .o_ovf        (w_core_ovf)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_mode   <= ModeFib;
         r_irq_en <= 1'b0;
         r_n      <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_ack <= w_hit;
         r_dat <= (w_hit && !wbs.wbs_we_i) ? w_rdata : '0;
         if (w_wr && w_reg == RegCtrl) begin
            r_irq_en <= w_wmerge[CtrlIrqEn];
            if (!w_busy) r_mode <= w_wmerge[CtrlMode];
         end
         if (w_wr && w_reg == RegN && !w_busy) r_n <= w_wmerge[NW-1:0];
         if (w_start) begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
         end
         if (w_wr && w_reg == RegStatus) begin
            if (w_wmerge[StatDone]) r_done <= 1'b0;
            if (w_wmerge[StatOvf])  r_ovf  <= 1'b0;
         end
         // Later assignment wins: completion beats a same-cycle clear.
         if (w_done_pulse) begin
            r_result <= w_core_result;
            r_done   <= 1'b1;
            r_ovf    <= w_core_ovf;
         end
      end
   end

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;
   assign irq           = r_done & r_irq_en;

   assign w_unused = ^{wbs.wbs_adr_i[1:0], w_wmerge[31:NW]};

endmodule

// File: tb/tb_fibonacci_wb.sv
// Directed self-checking bench for fibonacci_wb (W=32, NW=8).
module tb_fibonacci_wb;
   localparam logic [31:0] Base = 32'h3000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;
   int   errors = 0;
   int   checks = 0;
   int   busy_total = 0;
   int   busy_mark;

   fibonacci_wb_if u_if ();

   fibonacci_wb #(
      .W         (32),
      .NW        (8),
      .BASE_ADDR (Base)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (u_if),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (dut.u_core.o_busy === 1'b1) busy_total++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat, output logic got);
      got  = 1'b0;
      rdat = '0;
      @(posedge clk); #1;
      u_if.wbs_cyc_i = 1'b1;
      u_if.wbs_stb_i = 1'b1;
      u_if.wbs_we_i  = we;
      u_if.wbs_adr_i = adr;
      u_if.wbs_dat_i = wdat;
      u_if.wbs_sel_i = sel;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (u_if.wbs_ack_o === 1'b1) begin
            got  = 1'b1;
            rdat = u_if.wbs_dat_o;
         end
      end
      u_if.wbs_cyc_i = 1'b0;
      u_if.wbs_stb_i = 1'b0;
      u_if.wbs_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel = 4'hF);
      logic [31:0] x;
      logic        g;
      wb_xfer(Base + {28'b0, r, 2'b00}, 1'b1, d, sel, x, g);
      if (!g) check("write_ack_timeout", {31'b0, g}, 32'd1);
   endtask

   task automatic rd(input logic [1:0] r, output logic [31:0] d);
      logic g;
      wb_xfer(Base + {28'b0, r, 2'b00}, 1'b0, '0, 4'hF, d, g);
      if (!g) check("read_ack_timeout", {31'b0, g}, 32'd1);
   endtask

   // Poll STATUS until done; a missing done inside the budget is a failure.
   task automatic wait_done(output logic [31:0] st);
      st = '0;
      for (int i = 0; i < 100 && st[1] !== 1'b1; i++) rd(2'd3, st);
      if (st[1] !== 1'b1) check("done_timeout", st, 32'h2);
   endtask

   task automatic run(input string tag, input logic mode, input logic [7:0] n,
                      input logic [31:0] exp_res, input logic [31:0] exp_st,
                      input int exp_busy);
      logic [31:0] st, res;
      wr(2'd1, {24'b0, n});
      busy_mark = busy_total;
      wr(2'd0, {30'b0, mode, 1'b1});
      wait_done(st);
      check({tag, "_status"}, st, exp_st);
      rd(2'd2, res);
      check({tag, "_result"}, res, exp_res);
      check({tag, "_busy_cycles"}, busy_total - busy_mark, exp_busy);
   endtask

   initial begin
      logic [31:0] d;
      logic        g;
      u_if.wbs_cyc_i = 1'b0;
      u_if.wbs_stb_i = 1'b0;
      u_if.wbs_we_i  = 1'b0;
      u_if.wbs_sel_i = 4'h0;
      u_if.wbs_adr_i = '0;
      u_if.wbs_dat_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_ack", {31'b0, u_if.wbs_ack_o}, 32'd0);
      check("rst_dat", u_if.wbs_dat_o, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      rd(2'd0, d); check("rst_ctrl", d, 32'd0);
      rd(2'd1, d); check("rst_n", d, 32'd0);
      rd(2'd2, d); check("rst_result", d, 32'd0);
      rd(2'd3, d); check("rst_status", d, 32'd0);
      @(posedge clk); #1;
      check("ack_single_cycle", {31'b0, u_if.wbs_ack_o}, 32'd0);
      check("dat_zero_idle", u_if.wbs_dat_o, 32'd0);

      run("fib10", 1'b0, 8'd10, 32'd55, 32'h2, 11);
      run("luc10", 1'b1, 8'd10, 32'd123, 32'h2, 11);
      run("luc0", 1'b1, 8'd0, 32'd2, 32'h2, 1);
      run("fib0", 1'b0, 8'd0, 32'd0, 32'h2, 1);
      run("fib47", 1'b0, 8'd47, 32'd2971215073, 32'h2, 48);
      run("fib48", 1'b0, 8'd48, 32'h1E8D_0A40, 32'h6, 49);
      run("fib1", 1'b0, 8'd1, 32'd1, 32'h2, 2);

      // Interrupt gating and write-1-to-clear of done.
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h5);
      wait_done(d);
      check("irq_status", d, 32'h2);
      check("irq_high", {31'b0, irq}, 32'd1);
      rd(2'd2, d); check("irq_result", d, 32'd5);
      wr(2'd3, 32'h2);
      check("irq_cleared", {31'b0, irq}, 32'd0);
      rd(2'd3, d); check("status_cleared", d, 32'd0);
      wr(2'd0, 32'h0);

      // Writes while busy: N, mode and start ignored; irq_en still takes effect.
      wr(2'd1, 32'd20);
      wr(2'd0, 32'h1);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h7);
      rd(2'd1, d); check("busy_n_held", d, 32'd20);
      rd(2'd0, d); check("busy_ctrl", d, 32'h4);
      wait_done(d);
      rd(2'd2, d); check("busy_result", d, 32'd6765);
      check("busy_irq", {31'b0, irq}, 32'd1);
      wr(2'd3, 32'h6);
      wr(2'd0, 32'h0);

      // Byte enables on N.
      wr(2'd1, 32'h12);
      wr(2'd1, 32'h0000_05FF, 4'b0010);
      rd(2'd1, d); check("sel_lane1_only", d, 32'h12);
      wr(2'd1, 32'hFFFF_FF34, 4'b0001);
      rd(2'd1, d); check("sel_lane0", d, 32'h34);

      // Reset mid-run aborts with no completion.
      wr(2'd1, 32'd30);
      wr(2'd0, 32'h5);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("abort_irq", {31'b0, irq}, 32'd0);
      rd(2'd3, d); check("abort_status", d, 32'd0);
      rd(2'd2, d); check("abort_result", d, 32'd0);
      rd(2'd1, d); check("abort_n", d, 32'd0);
      repeat (40) @(posedge clk);
      #1 check("abort_no_late_irq", {31'b0, irq}, 32'd0);
      rd(2'd3, d); check("abort_no_late_done", d, 32'd0);

      // Address decode misses.
      wb_xfer(32'h3000_0010, 1'b0, '0, 4'hF, d, g);
      check("wrong_base_rd", {31'b0, g}, 32'd0);
      wb_xfer(32'h4000_0004, 1'b0, '0, 4'hF, d, g);
      check("wrong_base_rd2", {31'b0, g}, 32'd0);
      wb_xfer(32'h3000_0014, 1'b1, 32'h55, 4'hF, d, g);
      check("wrong_base_wr", {31'b0, g}, 32'd0);
      rd(2'd1, d); check("wrong_base_no_effect", d, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
